cond_checker: RTL and testbench

- Branch-condition evaluator for the PikaRISC execute stage.
- Inputs: the 4-bit condition field of a jump instruction and the current CPSR flags (N, Z, C, V). Output: whether the jump is taken.
- The decision path `taken` is purely combinational, so execute/fetch can redirect in the same cycle.
- A small clocked block supplies a one-cycle registered copy of `taken` and a saturating taken-branch counter for debug/performance.

---
 rtl/cond_checker.sv | 41 ++++
 tb/tb_cond_checker.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/cond_checker.sv
// cond_checker: PikaRISC branch-condition evaluator with registered taken copy and saturating taken counter
//   clk, rst (async, active-high)
//   cpsr_in[3:0] = {N,Z,C,V}, cond[3:0] condition code, is_jmp_op jump qualifier
//   taken, illegal_cond : combinational decision outputs
//   taken_q             : taken registered on clk
//   taken_cnt[CNT_W-1:0]: saturating count of cycles with taken=1
module cond_checker #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       cpsr_in,
  input  logic [3:0]       cond,
  input  logic             is_jmp_op,
  output logic             taken,
  output logic             illegal_cond,
  output logic             taken_q,
  output logic [CNT_W-1:0] taken_cnt
);
  logic        w_n, w_z, w_c, w_v, w_lt;
  logic [15:0] w_tbl;
  logic        r_q;
  logic [CNT_W-1:0] r_cnt;
  assign {w_n, w_z, w_c, w_v} = cpsr_in;
  assign w_lt = w_n ^ w_v;
  // bit k holds the truth of condition k; indexing keeps X on cond visible
  assign w_tbl = {1'b0, ~w_c | w_z, w_c & ~w_z, ~w_v, w_v, ~w_n, w_n, ~w_c, w_c,
                  w_lt, w_z | w_lt, ~w_z & ~w_lt, ~w_lt, ~w_z, w_z, 1'b1};
  assign taken        = is_jmp_op & w_tbl[cond];
  assign illegal_cond = is_jmp_op & (&cond);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_q   <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_q <= taken;
      if (taken && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
    end
  assign taken_q   = r_q;
  assign taken_cnt = r_cnt;
endmodule

// File: tb/tb_cond_checker.sv
// tb_cond_checker: scoreboard bench for cond_checker (16-bit and 2-bit counter instances)
module tb_cond_checker;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  cpsr_in = 4'h0;
  logic [3:0]  cond = 4'h0;
  logic        is_jmp_op = 1'b0;
  logic        taken, illegal_cond, taken_q, taken_b, illegal_b, taken_qb;
  logic [15:0] taken_cnt;
  logic [1:0]  taken_cnt_b;
  typedef struct {
    string       nm;
    int          k;
    logic        t, i, q;
    logic [15:0] c;
    logic [1:0]  cb;
  } exp_t;
  exp_t exp_q[$];
  event sample;
  int n_vec = 0;
  int n_err = 0;
  cond_checker dut (
    .clk(clk), .rst(rst), .cpsr_in(cpsr_in), .cond(cond), .is_jmp_op(is_jmp_op),
    .taken(taken), .illegal_cond(illegal_cond), .taken_q(taken_q), .taken_cnt(taken_cnt)
  );
  cond_checker #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .cpsr_in(cpsr_in), .cond(cond), .is_jmp_op(is_jmp_op),
    .taken(taken_b), .illegal_cond(illegal_b), .taken_q(taken_qb), .taken_cnt(taken_cnt_b)
  );
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got t=%0t required finish", $time);
    $fatal(1, "timeout");
  end
  initial forever begin
    exp_t e;
    @(sample);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (e.k == 0) begin
        if (taken !== e.t || illegal_cond !== e.i)
          begin n_err++; $display("FAIL %s: got taken=%b illegal=%b, required taken=%b illegal=%b", e.nm, taken, illegal_cond, e.t, e.i); end
      end else begin
        if (taken_q !== e.q || taken_cnt !== e.c || taken_cnt_b !== e.cb)
          begin n_err++; $display("FAIL %s: got taken_q=%b cnt=%0d cnt2=%0d, required taken_q=%b cnt=%0d cnt2=%0d", e.nm, taken_q, taken_cnt, taken_cnt_b, e.q, e.c, e.cb); end
      end
    end
  end
  task automatic cv(input string nm, input logic [3:0] cd, input logic [3:0] f, input logic j, input logic et, input logic ei);
    exp_t e;
    cond = cd; cpsr_in = f; is_jmp_op = j;
    e.nm = nm; e.k = 0; e.t = et; e.i = ei; e.q = 1'b0; e.c = '0; e.cb = '0;
    exp_q.push_back(e);
    -> sample;
    #3;
  endtask
  task automatic sv(input string nm, input logic eq, input logic [15:0] ec, input logic [1:0] ecb);
    exp_t e;
    e.nm = nm; e.k = 1; e.t = 1'b0; e.i = 1'b0; e.q = eq; e.c = ec; e.cb = ecb;
    exp_q.push_back(e);
    -> sample;
    #2;
  endtask
  task automatic edge_chk(input string nm, input logic eq, input logic [15:0] ec, input logic [1:0] ecb);
    @(posedge clk);
    #1;
    sv(nm, eq, ec, ecb);
  endtask
  initial begin
    #1;
    cv("jmp_0000", 4'd0, 4'b0000, 1, 1, 0);
    cv("jmp_1111", 4'd0, 4'b1111, 1, 1, 0);
    cv("jeq_0000", 4'd1, 4'b0000, 1, 0, 0);
    cv("jeq_1111", 4'd1, 4'b1111, 1, 1, 0);
    cv("jeq_1011", 4'd1, 4'b1011, 1, 0, 0);
    cv("jeq_0100", 4'd1, 4'b0100, 1, 1, 0);
    cv("jne_0000", 4'd2, 4'b0000, 1, 1, 0);
    cv("jne_1111", 4'd2, 4'b1111, 1, 0, 0);
    cv("jne_1011", 4'd2, 4'b1011, 1, 1, 0);
    cv("jne_0100", 4'd2, 4'b0100, 1, 0, 0);
    cv("jge_0000", 4'd3, 4'b0000, 1, 1, 0);
    cv("jge_1111", 4'd3, 4'b1111, 1, 1, 0);
    cv("jge_1001", 4'd3, 4'b1001, 1, 1, 0);
    cv("jge_0110", 4'd3, 4'b0110, 1, 1, 0);
    cv("jge_1100", 4'd3, 4'b1100, 1, 0, 0);
    cv("jge_0011", 4'd3, 4'b0011, 1, 0, 0);
    cv("jlt_0000", 4'd6, 4'b0000, 1, 0, 0);
    cv("jlt_1111", 4'd6, 4'b1111, 1, 0, 0);
    cv("jlt_1100", 4'd6, 4'b1100, 1, 1, 0);
    cv("jlt_0011", 4'd6, 4'b0011, 1, 1, 0);
    cv("jlt_1010", 4'd6, 4'b1010, 1, 1, 0);
    cv("jlt_0101", 4'd6, 4'b0101, 1, 1, 0);
    cv("jgt_0000", 4'd4, 4'b0000, 1, 1, 0);
    cv("jgt_1111", 4'd4, 4'b1111, 1, 0, 0);
    cv("jgt_1001", 4'd4, 4'b1001, 1, 1, 0);
    cv("jgt_1011", 4'd4, 4'b1011, 1, 1, 0);
    cv("jgt_1100", 4'd4, 4'b1100, 1, 0, 0);
    cv("jgt_0010", 4'd4, 4'b0010, 1, 1, 0);
    cv("jle_0000", 4'd5, 4'b0000, 1, 0, 0);
    cv("jle_1111", 4'd5, 4'b1111, 1, 1, 0);
    cv("jle_0100", 4'd5, 4'b0100, 1, 1, 0);
    cv("jle_1011", 4'd5, 4'b1011, 1, 0, 0);
    cv("jle_0010", 4'd5, 4'b0010, 1, 0, 0);
    cv("jle_1100", 4'd5, 4'b1100, 1, 1, 0);
    cv("jcs_0010", 4'd7, 4'b0010, 1, 1, 0);
    cv("jcs_1101", 4'd7, 4'b1101, 1, 0, 0);
    cv("jcc_0010", 4'd8, 4'b0010, 1, 0, 0);
    cv("jcc_0000", 4'd8, 4'b0000, 1, 1, 0);
    cv("jmi_1000", 4'd9, 4'b1000, 1, 1, 0);
    cv("jmi_0111", 4'd9, 4'b0111, 1, 0, 0);
    cv("jpl_1000", 4'd10, 4'b1000, 1, 0, 0);
    cv("jpl_0111", 4'd10, 4'b0111, 1, 1, 0);
    cv("jvs_0001", 4'd11, 4'b0001, 1, 1, 0);
    cv("jvs_1110", 4'd11, 4'b1110, 1, 0, 0);
    cv("jvc_0001", 4'd12, 4'b0001, 1, 0, 0);
    cv("jvc_1110", 4'd12, 4'b1110, 1, 1, 0);
    cv("jhi_0010", 4'd13, 4'b0010, 1, 1, 0);
    cv("jhi_0110", 4'd13, 4'b0110, 1, 0, 0);
    cv("jhi_0000", 4'd13, 4'b0000, 1, 0, 0);
    cv("jls_0110", 4'd14, 4'b0110, 1, 1, 0);
    cv("jls_0010", 4'd14, 4'b0010, 1, 0, 0);
    cv("jls_0000", 4'd14, 4'b0000, 1, 1, 0);
    cv("rsv_0000", 4'd15, 4'b0000, 1, 0, 1);
    cv("rsv_1111", 4'd15, 4'b1111, 1, 0, 1);
    for (int c = 0; c < 16; c++) cv($sformatf("nojmp_c%0d", c), 4'(c), 4'b1111, 0, 0, 0);
    sv("reset_hold", 0, 16'd0, 2'd0);
    @(negedge clk);
    cond = 4'd0; cpsr_in = 4'b0000; is_jmp_op = 1'b1; rst = 1'b0;
    edge_chk("cnt_e1", 1, 16'd1, 2'd1);
    edge_chk("cnt_e2", 1, 16'd2, 2'd2);
    edge_chk("cnt_e3", 1, 16'd3, 2'd3);
    edge_chk("cnt_e4", 1, 16'd4, 2'd3);
    edge_chk("cnt_e5", 1, 16'd5, 2'd3);
    edge_chk("cnt_e6", 1, 16'd6, 2'd3);
    @(negedge clk);
    cond = 4'd15;
    edge_chk("not_taken_edge", 0, 16'd6, 2'd3);
    @(negedge clk);
    cond = 4'd0;
    edge_chk("taken_again", 1, 16'd7, 2'd3);
    @(posedge clk);
    #3;
    rst = 1'b1;
    sv("async_reset", 0, 16'd0, 2'd0);
    cv("taken_in_reset", 4'd0, 4'b0000, 1, 1, 0);
    @(negedge clk);
    rst = 1'b0;
    edge_chk("after_release", 1, 16'd1, 2'd1);
    @(negedge clk);
    is_jmp_op = 1'b0;
    edge_chk("idle_edge", 0, 16'd1, 2'd1);
    #10;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
